// File: rtl/rf_param_nr1w_pkg.sv
// Shared types and helpers for the parametrised multi-read register file.
// Latency: n/a (types and elaboration-time functions only).
// Backpressure: n/a.
package rf_pkg;

  // Clear engine states.
  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_SWEEP = 1'b1
  } rf_state_e;

  // Upper bound on the number of read ports a single file may expose.
  localparam int RF_MAX_NRD = 4;

  // Address width for a given depth; never narrower than one bit.
  function automatic int rf_aw(input int depth);
    int a;
    a = $clog2(depth);
    return (a < 1) ? 1 : a;
  endfunction

endpackage

// File: rtl/rf_param_nr1w_if.sv
// Write/read/clear bus of the register file; master drives requests, slave is the file.
// Latency: n/a (wiring only).
// Backpressure: none on the bus itself; rejected writes are reported through wr_drop.
interface rf_param_nr1w_if
  import rf_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int NRD   = 2
);
  localparam int AW = rf_aw(DEPTH);

  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [WIDTH-1:0]     wr_data;
  logic [NRD-1:0]       rd_en;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*WIDTH-1:0] rd_data;
  logic [NRD-1:0]       rd_vld;
  logic                 clr_req;
  logic                 busy;
  logic                 wr_drop;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr, clr_req,
    input  rd_data, rd_vld, busy, wr_drop
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr, clr_req,
    output rd_data, rd_vld, busy, wr_drop
  );

endinterface

// File: rtl/rf_param_nr1w_read_port.sv
// One read port: address range check, write-to-read bypass, optional output register.
// Latency: 0 cycles when RD_LAT=0, 1 cycle (captured on rd_en) when RD_LAT=1.
// Backpressure: none; with RD_LAT=1 the output holds while rd_en is low.
module rf_read_port #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int RD_LAT = 0,
  parameter int BYPASS = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rd_en,
  input  logic [AW-1:0]               rd_addr,
  input  logic [DEPTH-1:0][WIDTH-1:0] mem,
  input  logic [DEPTH-1:0]            flag,
  input  logic                        wr_acc,
  input  logic [AW-1:0]               wr_addr,
  input  logic [WIDTH-1:0]            wr_data,
  output logic [WIDTH-1:0]            rd_data,
  output logic                        rd_vld
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] sel_data;
  logic             sel_vld;

  // Select the entry, the in-flight write data, or zero for an out-of-range address.
  always_comb begin
    sel_data = '0;
    sel_vld  = 1'b0;
    if ({1'b0, rd_addr} < DEPTH_W) begin
      if ((BYPASS != 0) && wr_acc && (wr_addr == rd_addr)) begin
        sel_data = wr_data;
        sel_vld  = 1'b1;
      end else begin
        sel_data = mem[rd_addr];
        sel_vld  = flag[rd_addr];
      end
    end
  end

  if (RD_LAT != 0) begin : g_reg
    logic [WIDTH-1:0] data_q;
    logic             vld_q;

    // Capture the selected entry only on an enabled read; otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q <= '0;
        vld_q  <= 1'b0;
      end else if (rd_en) begin
        data_q <= sel_data;
        vld_q  <= sel_vld;
      end
    end

    assign rd_data = data_q;
    assign rd_vld  = vld_q;
  end else begin : g_comb
    // Combinational port has no use for the clock, reset or enable.
    logic unused_comb_port;
    assign unused_comb_port = ^{clk, rst_n, rd_en};
    assign rd_data = sel_data;
    assign rd_vld  = sel_vld;
  end

endmodule

// File: rtl/rf_param_nr1w.sv
// Register file with one write port, NRD read ports, written flags and a one-entry-per-cycle clear sweep.
// Latency: write visible next cycle (same cycle via bypass); read 0 or 1 cycle per RD_LAT; clear takes DEPTH cycles.
// Backpressure: writes during a sweep or to an out-of-range address are dropped and flagged on wr_drop next cycle.
module rf_param_nr1w
  import rf_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int NRD    = 2,
  parameter int RD_LAT = 0,
  parameter int BYPASS = 1
) (
  input logic             clk,
  input logic             rst_n,
  rf_param_nr1w_if.slave  bus
);

  localparam int          AW      = rf_aw(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [DEPTH-1:0]            flag;
  rf_state_e                   state;
  logic [AW-1:0]               ptr;
  logic                        busy_q;
  logic                        wr_drop_q;
  logic                        wr_in_range;
  logic                        wr_acc;
  logic [NRD-1:0][WIDTH-1:0]   rd_data_p;
  logic [NRD-1:0]              rd_vld_p;

  assign wr_in_range = {1'b0, bus.wr_addr} < DEPTH_W;
  assign wr_acc      = bus.wr_en && !busy_q && wr_in_range;

  // Storage: accepted writes set data and flag; the sweep zeroes one entry per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem  <= '0;
      flag <= '0;
    end else if (wr_acc) begin
      mem[bus.wr_addr]  <= bus.wr_data;
      flag[bus.wr_addr] <= 1'b1;
    end else if (state == RF_SWEEP) begin
      mem[ptr]  <= '0;
      flag[ptr] <= 1'b0;
    end
  end

  // Clear engine: IDLE waits for clr_req, SWEEP walks ptr to DEPTH-1; busy is registered with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RF_IDLE;
      ptr    <= '0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        RF_IDLE: begin
          if (bus.clr_req) begin
            state  <= RF_SWEEP;
            ptr    <= '0;
            busy_q <= 1'b1;
          end
        end
        RF_SWEEP: begin
          if (ptr == LAST) begin
            state  <= RF_IDLE;
            ptr    <= '0;
            busy_q <= 1'b0;
          end else begin
            ptr <= ptr + AW'(1);
          end
        end
        default: begin
          state  <= RF_IDLE;
          ptr    <= '0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // One-cycle flag for a write request that was not accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_drop_q <= 1'b0;
    end else begin
      wr_drop_q <= bus.wr_en && !wr_acc;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    rf_read_port #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW),
      .RD_LAT(RD_LAT),
      .BYPASS(BYPASS)
    ) u_port (
      .clk    (clk),
      .rst_n  (rst_n),
      .rd_en  (bus.rd_en[p]),
      .rd_addr(bus.rd_addr[p*AW +: AW]),
      .mem    (mem),
      .flag   (flag),
      .wr_acc (wr_acc),
      .wr_addr(bus.wr_addr),
      .wr_data(bus.wr_data),
      .rd_data(rd_data_p[p]),
      .rd_vld (rd_vld_p[p])
    );
  end

  assign bus.rd_data = rd_data_p;
  assign bus.rd_vld  = rd_vld_p;
  assign bus.busy    = busy_q;
  assign bus.wr_drop = wr_drop_q;

endmodule
